// File: rtl/formula_sweep_ctrl_pkg.sv
// Shared definitions for the formula sweep controller.
//   - sweep_state_e : FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - N_IN_DEF      : default formula input width
//   - CNT_W_DEF     : default eval/miss counter width
//   - min_cnt_w()   : smallest counter width that can hold 2^n_in
package formula_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  // A full sweep retires 2^n_in vectors, which needs one bit more than n_in.
  function automatic int min_cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  localparam int N_IN_DEF  = 19;
  localparam int CNT_W_DEF = min_cnt_w(N_IN_DEF);

endpackage

// File: rtl/formula_sweep_retire.sv
// Retire stage of the formula sweep: holds the one in-flight result (s1),
// compares it against the expected value and accumulates the results.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr_i             clear results (accepted start)
//   issue_i           capture vec_i/out_i into s1 this edge
//   vec_i, out_i      vector being issued and the formula output for it
//   expect_i          required formula output
//   miss_now_o        s1 holds a miss that retires this cycle
//   miss_found_o      at least one miss retired
//   miss_vec_o        first vector that missed
//   miss_count_o      saturating miss counter
//   eval_count_o      number of vectors retired
module formula_sweep_retire
  import formula_sweep_ctrl_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             issue_i,
  input  logic [N_IN-1:0]  vec_i,
  input  logic             out_i,
  input  logic             expect_i,
  output logic             miss_now_o,
  output logic             miss_found_o,
  output logic [N_IN-1:0]  miss_vec_o,
  output logic [CNT_W-1:0] miss_count_o,
  output logic [CNT_W-1:0] eval_count_o
);

  logic             s1_vld_q;
  logic [N_IN-1:0]  s1_vec_q;
  logic             s1_out_q;
  logic [CNT_W-1:0] eval_q, eval_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             found_q, found_d;
  logic [N_IN-1:0]  mvec_q, mvec_d;

  assign miss_now_o = s1_vld_q && (s1_out_q != expect_i);

  always_comb begin
    eval_d     = eval_q;
    miss_cnt_d = miss_cnt_q;
    found_d    = found_q;
    mvec_d     = mvec_q;
    if (clr_i) begin
      eval_d     = '0;
      miss_cnt_d = '0;
      found_d    = 1'b0;
      mvec_d     = '0;
    end else if (s1_vld_q) begin
      eval_d = eval_q + CNT_W'(1);
      if (miss_now_o) begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        // Only the first miss of a sweep is recorded.
        if (!found_q) begin
          found_d = 1'b1;
          mvec_d  = s1_vec_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_vec_q   <= '0;
      s1_out_q   <= 1'b0;
      eval_q     <= '0;
      miss_cnt_q <= '0;
      found_q    <= 1'b0;
      mvec_q     <= '0;
    end else begin
      s1_vld_q <= issue_i;
      if (issue_i) begin
        s1_vec_q <= vec_i;
        s1_out_q <= out_i;
      end
      eval_q     <= eval_d;
      miss_cnt_q <= miss_cnt_d;
      found_q    <= found_d;
      mvec_q     <= mvec_d;
    end
  end

  assign miss_found_o = found_q;
  assign miss_vec_o   = mvec_q;
  assign miss_count_o = miss_cnt_q;
  assign eval_count_o = eval_q;

endmodule

// File: rtl/formula_sweep_ctrl.sv
// Sweep sequencer: drives a combinational formula with every vector in
// [range_lo_i, range_hi_i], one per cycle, and checks each output against
// expect_i. Results: eval count, saturating miss count, first miss vector.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i                  begin a sweep (sampled only in IDLE)
//   abort_i                  end a running sweep early
//   pause_i                  hold issue; the in-flight result still retires
//   range_lo_i, range_hi_i   inclusive vector range
//   expect_i                 required formula output
//   stop_on_miss_i           end the sweep at the first miss
//   f_vec_o / f_out_i        formula input vector / formula output
//   busy_o                   high in RUN and DRAIN
//   done_o, aborted_o        one-cycle end pulse; aborted valid with done
//   miss_found_o, miss_vec_o, miss_count_o, eval_count_o   results
//   state_o                  current FSM state (debug)
// Control handshake: start_i is a single-cycle request honoured only while
// busy_o=0 and done_o=0; each accepted start yields exactly one done_o pulse
// unless rst intervenes. Results hold from done_o until the next accepted start.
module formula_sweep_ctrl
  import formula_sweep_ctrl_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             pause_i,
  input  logic [N_IN-1:0]  range_lo_i,
  input  logic [N_IN-1:0]  range_hi_i,
  input  logic             expect_i,
  input  logic             stop_on_miss_i,
  output logic [N_IN-1:0]  f_vec_o,
  input  logic             f_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             miss_found_o,
  output logic [N_IN-1:0]  miss_vec_o,
  output logic [CNT_W-1:0] miss_count_o,
  output logic [CNT_W-1:0] eval_count_o,
  output logic [1:0]       state_o
);

  if (CNT_W < min_cnt_w(N_IN)) begin : g_cnt_w_check
    $error("formula_sweep_ctrl: CNT_W must be at least N_IN+1");
  end

  sweep_state_e    state_q, state_d;
  logic [N_IN-1:0] f_vec_q, f_vec_d;
  logic [N_IN-1:0] range_hi_q, range_hi_d;
  logic            expect_q, expect_d;
  logic            stop_q, stop_d;
  logic            aborted_q, aborted_d;
  logic            issue;
  logic            clr;
  logic            miss_now;

  always_comb begin
    state_d    = state_q;
    f_vec_d    = f_vec_q;
    range_hi_d = range_hi_q;
    expect_d   = expect_q;
    stop_d     = stop_q;
    aborted_d  = aborted_q;
    issue      = 1'b0;
    clr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          clr       = 1'b1;
          aborted_d = 1'b0;
          if (range_lo_i <= range_hi_i) begin
            range_hi_d = range_hi_i;
            expect_d   = expect_i;
            stop_d     = stop_on_miss_i;
            f_vec_d    = range_lo_i;
            state_d    = RUN;
          end else begin
            state_d = DONE;  // empty range: finish with cleared results
          end
        end
      end
      RUN: begin
        // abort outranks a stop_on_miss stop; both discard this cycle's issue
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (stop_q && miss_now) begin
          state_d = DONE;
        end else if (!pause_i) begin
          issue = 1'b1;
          // Stopping at range_hi keeps f_vec from wrapping at all-ones.
          if (f_vec_q == range_hi_q) state_d = DRAIN;
          else                       f_vec_d = f_vec_q + N_IN'(1);
        end
      end
      DRAIN: begin
        if (abort_i) aborted_d = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      f_vec_q    <= '0;
      range_hi_q <= '0;
      expect_q   <= 1'b0;
      stop_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_vec_q    <= f_vec_d;
      range_hi_q <= range_hi_d;
      expect_q   <= expect_d;
      stop_q     <= stop_d;
      aborted_q  <= aborted_d;
    end
  end

  formula_sweep_retire #(
    .N_IN  (N_IN),
    .CNT_W (CNT_W)
  ) u_retire (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .issue_i      (issue),
    .vec_i        (f_vec_q),
    .out_i        (f_out_i),
    .expect_i     (expect_q),
    .miss_now_o   (miss_now),
    .miss_found_o (miss_found_o),
    .miss_vec_o   (miss_vec_o),
    .miss_count_o (miss_count_o),
    .eval_count_o (eval_count_o)
  );

  assign f_vec_o   = f_vec_q;
  assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);
  assign aborted_o = aborted_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_formula_sweep_ctrl.sv
// Bench for formula_sweep_ctrl with a 10-bit formula so a full-range sweep
// stays short. The formula is a stub selected by mode:
//   0: f_out = f_vec[0]   1: f_out = 1   2: random truth table
module tb_formula_sweep_ctrl;
  localparam int TN   = 10;
  localparam int TC   = 11;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst, start_i, abort_i, pause_i, expect_i, stop_on_miss_i;
  logic [TN-1:0] range_lo_i, range_hi_i, f_vec_o, miss_vec_o;
  logic          f_out, busy_o, done_o, aborted_o, miss_found_o;
  logic [TC-1:0] miss_count_o, eval_count_o;
  logic [1:0]    state_o;

  int   mode;
  logic tt [0:(1<<TN)-1];
  bit   pause_s [0:MAXC-1];
  bit   abort_s [0:MAXC-1];
  logic [31:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int lo; int hi; bit ex; bit stop; int mode;
    int p_lo; int p_hi; int ab_at;
    int ev; int mc; int mv; bit mf; bit ab; int lat;
  } vec_t;
  vec_t tbl [0:8];

  // clock/reset block
  always #5 clk = ~clk;

  assign f_out = (mode == 0) ? f_vec_o[0] : (mode == 1) ? 1'b1 : tt[f_vec_o];

  formula_sweep_ctrl #(.N_IN(TN), .CNT_W(TC)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .pause_i(pause_i),
    .range_lo_i(range_lo_i), .range_hi_i(range_hi_i), .expect_i(expect_i),
    .stop_on_miss_i(stop_on_miss_i), .f_vec_o(f_vec_o), .f_out_i(f_out),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .miss_found_o(miss_found_o), .miss_vec_o(miss_vec_o),
    .miss_count_o(miss_count_o), .eval_count_o(eval_count_o), .state_o(state_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic fout_of(input int v);
    if (mode == 0) return v[0];
    else if (mode == 1) return 1'b1;
    else return tt[v];
  endfunction

  // Reference model: steps the sweep as issue/retire events per cycle after
  // start acceptance; pushes eval, miss, miss_vec, found, aborted, latency, busy.
  task automatic model_sweep(input int lo, input int hi, input bit ex, input bit stop);
    int ev = 0, mc = 0, mv = 0, k = 0, v, fl = 0;
    bit mf = 0, ab = 0, infl = 0, drain = 0, fin = 0, rmiss;
    if (lo > hi) begin
      repeat (7) exp_q.push_back(32'd0);
      return;
    end
    v = lo;
    while (!fin && k < MAXC) begin
      rmiss = 0;
      if (infl) begin
        ev++;
        if (fout_of(fl) != ex) begin
          mc++;
          rmiss = 1;
          if (!mf) begin mf = 1; mv = fl; end
        end
        infl = 0;
      end
      if (drain) begin ab = abort_s[k]; fin = 1; end
      else if (abort_s[k]) begin ab = 1; fin = 1; end
      else if (stop && rmiss) fin = 1;
      else if (!pause_s[k]) begin
        infl = 1; fl = v;
        if (v == hi) drain = 1; else v++;
      end
      k++;
    end
    exp_q.push_back(32'(ev)); exp_q.push_back(32'(mc)); exp_q.push_back(32'(mv));
    exp_q.push_back(32'(mf)); exp_q.push_back(32'(ab)); exp_q.push_back(32'(k));
    exp_q.push_back(32'd1);
  endtask

  task automatic push_tbl(input vec_t t);
    exp_q.push_back(32'(t.ev)); exp_q.push_back(32'(t.mc)); exp_q.push_back(32'(t.mv));
    exp_q.push_back(32'(t.mf)); exp_q.push_back(32'(t.ab)); exp_q.push_back(32'(t.lat));
    exp_q.push_back(32'(t.lo <= t.hi));
  endtask

  task automatic set_sched(input int p_lo, input int p_hi, input int ab_at);
    for (int k = 0; k < MAXC; k++) begin
      pause_s[k] = (k >= p_lo) && (k <= p_hi);
      abort_s[k] = (k == ab_at);
    end
  endtask

  // driver: called at a negedge with the DUT idle
  task automatic run_sweep(input int lo, input int hi, input bit ex, input bit stop,
                           input bit glitch, output int lat, output bit busy_seen);
    int k = 0;
    range_lo_i = TN'(lo); range_hi_i = TN'(hi);
    expect_i = ex; stop_on_miss_i = stop; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    busy_seen = 0;
    while (!done_o && k < MAXC) begin
      if (busy_o) busy_seen = 1;
      pause_i = pause_s[k];
      abort_i = abort_s[k];
      if (glitch && k == 2) begin
        start_i = 1'b1; range_lo_i = TN'(100); range_hi_i = TN'(200);
      end else start_i = 1'b0;
      @(negedge clk);
      k++;
    end
    pause_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
    lat = k;
  endtask

  // scoreboard compare
  task automatic check_results(input string tag, input int lat, input bit busy_seen);
    logic [31:0] e_ev, e_mc, e_mv, e_mf, e_ab, e_lat, e_busy;
    e_ev = exp_q.pop_front(); e_mc = exp_q.pop_front(); e_mv = exp_q.pop_front();
    e_mf = exp_q.pop_front(); e_ab = exp_q.pop_front(); e_lat = exp_q.pop_front();
    e_busy = exp_q.pop_front();
    chk({tag, " done_seen"}, 32'(done_o), 32'd1);
    chk({tag, " latency"}, 32'(lat), e_lat);
    chk({tag, " eval_count"}, 32'(eval_count_o), e_ev);
    chk({tag, " miss_count"}, 32'(miss_count_o), e_mc);
    chk({tag, " miss_vec"}, 32'(miss_vec_o), e_mv);
    chk({tag, " miss_found"}, 32'(miss_found_o), e_mf);
    chk({tag, " aborted"}, 32'(aborted_o), e_ab);
    chk({tag, " busy_seen"}, 32'(busy_seen), e_busy);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done_o), 32'd0);
    chk({tag, " busy_after"}, 32'(busy_o), 32'd0);
    chk({tag, " eval_hold"}, 32'(eval_count_o), e_ev);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, 32'(busy_o), 0);
    chk({tag, " done"}, 32'(done_o), 0);
    chk({tag, " aborted"}, 32'(aborted_o), 0);
    chk({tag, " miss_found"}, 32'(miss_found_o), 0);
    chk({tag, " miss_vec"}, 32'(miss_vec_o), 0);
    chk({tag, " miss_count"}, 32'(miss_count_o), 0);
    chk({tag, " eval_count"}, 32'(eval_count_o), 0);
    chk({tag, " f_vec"}, 32'(f_vec_o), 0);
    chk({tag, " state"}, 32'(state_o), 0);
  endtask

  initial begin
    int lat;
    bit bs;
    int dseen;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; pause_i = 1'b0;
    range_lo_i = '0; range_hi_i = '0; expect_i = 1'b0; stop_on_miss_i = 1'b0;
    mode = 0;
    for (int i = 0; i < (1 << TN); i++) tt[i] = 1'($urandom_range(0, 1));

    //            lo    hi    ex    stop  md pl  ph  ab  ev    mc  mv    mf    ab    lat
    tbl[0] = '{0,    7,    1'b1, 1'b0, 0, -1, -1, -1, 8,    4,  0,    1'b1, 1'b0, 9};
    tbl[1] = '{3,    10,   1'b1, 1'b1, 0, -1, -1, -1, 2,    1,  4,    1'b1, 1'b0, 3};
    tbl[2] = '{0,    1023, 1'b1, 1'b0, 1, -1, -1, -1, 1024, 0,  0,    1'b0, 1'b0, 1025};
    tbl[3] = '{9,    4,    1'b1, 1'b0, 0, -1, -1, -1, 0,    0,  0,    1'b0, 1'b0, 0};
    tbl[4] = '{0,    15,   1'b1, 1'b0, 0, 3,  5,  8,  5,    3,  0,    1'b1, 1'b1, 9};
    tbl[5] = '{5,    5,    1'b0, 1'b0, 0, -1, -1, -1, 1,    1,  5,    1'b1, 1'b0, 2};
    tbl[6] = '{0,    3,    1'b1, 1'b0, 0, -1, -1, 4,  4,    2,  0,    1'b1, 1'b1, 5};
    tbl[7] = '{3,    10,   1'b1, 1'b1, 0, -1, -1, 2,  2,    1,  4,    1'b1, 1'b1, 3};
    tbl[8] = '{1000, 1023, 1'b0, 1'b0, 1, -1, -1, -1, 24,   24, 1000, 1'b1, 1'b0, 25};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      mode = tbl[i].mode;
      set_sched(tbl[i].p_lo, tbl[i].p_hi, tbl[i].ab_at);
      push_tbl(tbl[i]);
      run_sweep(tbl[i].lo, tbl[i].hi, tbl[i].ex, tbl[i].stop, 1'b0, lat, bs);
      check_results($sformatf("tbl%0d", i), lat, bs);
    end

    // start pulsed while busy must be ignored
    mode = 0;
    set_sched(-1, -1, -1);
    push_tbl(tbl[0]);
    run_sweep(0, 7, 1'b1, 1'b0, 1'b1, lat, bs);
    check_results("start_while_busy", lat, bs);

    // reset mid-sweep: everything cleared, no done pulse, then a clean sweep
    range_lo_i = TN'(0); range_hi_i = TN'(100); expect_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    rst = 1'b0;
    dseen = 0;
    repeat (120) begin
      @(negedge clk);
      if (done_o) dseen++;
    end
    chk("mid_reset no_done", 32'(dseen), 0);
    push_tbl(tbl[0]);
    run_sweep(0, 7, 1'b1, 1'b0, 1'b0, lat, bs);
    check_results("after_reset", lat, bs);

    // randomized sweeps against the reference model
    for (int r = 0; r < 40; r++) begin
      int lo, hi, len;
      bit ex, stop;
      mode = 2;
      lo = $urandom_range(0, (1 << TN) - 1);
      len = $urandom_range(0, 40);
      hi = (lo + len > (1 << TN) - 1) ? (1 << TN) - 1 : lo + len;
      if ($urandom_range(0, 7) == 0 && lo > 0) hi = $urandom_range(0, lo - 1);
      ex = 1'($urandom_range(0, 1));
      stop = 1'($urandom_range(0, 1));
      for (int k = 0; k < MAXC; k++) begin
        pause_s[k] = ($urandom_range(0, 3) == 0);
        abort_s[k] = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) abort_s[$urandom_range(0, len + 2)] = 1'b1;
      model_sweep(lo, hi, ex, stop);
      run_sweep(lo, hi, ex, stop, 1'b0, lat, bs);
      check_results($sformatf("rand%0d", r), lat, bs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
